// File: rtl/phy_tx_arbiter.sv
// Two-requester, slot-based word arbiter in front of a phy transmit port.
// A burst of sync words runs after reset; then at most one word is granted per slot, with round-robin on contention.
module phy_tx_arbiter #(
  parameter int unsigned WORD_PERIOD  = 16,
  parameter int unsigned SYNC_WORDS   = 4,
  parameter logic [31:0] SYNC_PATTERN = 32'hBCBC_BCBC
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        req_0,
  input  logic [31:0] data_0,
  input  logic        req_1,
  input  logic [31:0] data_1,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic        valid_in,
  output logic [31:0] Data_in,
  output logic        link_ready,
  output logic        owner
);

  typedef enum logic [0:0] {
    ST_SYNC = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

  localparam logic [7:0] LAST_SLOT = 8'(WORD_PERIOD - 1);
  localparam logic [3:0] LAST_SYNC = 4'(SYNC_WORDS - 1);

  state_e      state_q, state_d;
  logic [7:0]  slot_cnt_q, slot_cnt_d;
  logic [3:0]  sync_cnt_q, sync_cnt_d;
  logic        rr_q, rr_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        link_q, link_d;
  logic        owner_q, owner_d;

  logic        slot_tick_s;
  logic        win_s;
  logic        win_id_s;

  assign slot_tick_s = (slot_cnt_q == LAST_SLOT);

  // Winner selection: a lone request wins outright, contention goes to the rr pointer
  always_comb begin
    win_s    = 1'b0;
    win_id_s = 1'b0;
    if (req_0 && req_1) begin
      win_s    = 1'b1;
      win_id_s = rr_q;
    end else if (req_0) begin
      win_s    = 1'b1;
      win_id_s = 1'b0;
    end else if (req_1) begin
      win_s    = 1'b1;
      win_id_s = 1'b1;
    end else begin
      win_s    = 1'b0;
      win_id_s = 1'b0;
    end
  end

  // Next-state and output decode; everything holds between slot ticks except the grant pulses
  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    rr_d       = rr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    link_d     = link_q;
    owner_d    = owner_q;
    if (slot_tick_s) begin
      slot_cnt_d = 8'd0;
    end else begin
      slot_cnt_d = slot_cnt_q + 8'd1;
    end

    case (state_q)
      ST_SYNC: begin
        if (slot_tick_s) begin
          valid_d    = 1'b1;
          data_d     = SYNC_PATTERN;
          sync_cnt_d = sync_cnt_q + 4'd1;
          if (sync_cnt_q == LAST_SYNC) begin
            state_d = ST_ARB;
            link_d  = 1'b1;
          end else begin
            state_d = ST_SYNC;
          end
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_ARB: begin
        if (slot_tick_s) begin
          if (win_s) begin
            valid_d = 1'b1;
            data_d  = win_id_s ? data_1 : data_0;
            owner_d = win_id_s;
            rr_d    = ~win_id_s;
            gnt0_d  = ~win_id_s;
            gnt1_d  = win_id_s;
          end else begin
            valid_d = 1'b0;
            data_d  = 32'h0000_0000;
          end
        end else begin
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // State and output registers, cleared asynchronously while reset is low
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SYNC;
      slot_cnt_q <= 8'd0;
      sync_cnt_q <= 4'd0;
      rr_q       <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 32'h0000_0000;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      link_q     <= 1'b0;
      owner_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      rr_q       <= rr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      link_q     <= link_d;
      owner_q    <= owner_d;
    end
  end

  assign gnt_0      = gnt0_q;
  assign gnt_1      = gnt1_q;
  assign valid_in   = valid_q;
  assign Data_in    = data_q;
  assign link_ready = link_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Scoreboard bench: expected slot results are queued as requests are driven and compared at each slot boundary.
module tb_phy_tx_arbiter;

  localparam int          WP  = 16;
  localparam int          SW  = 4;
  localparam logic [31:0] PAT = 32'hBCBC_BCBC;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        o;
    logic        g0;
    logic        g1;
    logic        lr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_0, req_1;
  logic [31:0] data_0, data_1;
  logic        gnt_0, gnt_1, valid_in, link_ready, owner;
  logic [31:0] Data_in;

  logic        rst_b, req_0b, req_1b;
  logic [31:0] data_0b, data_1b;
  logic        gnt_0b, gnt_1b, valid_b, link_b, owner_b;
  logic [31:0] Data_b;

  phy_tx_arbiter #(.WORD_PERIOD(WP), .SYNC_WORDS(SW), .SYNC_PATTERN(PAT)) dut (
    .clk_32f(clk), .reset(reset), .req_0(req_0), .data_0(data_0), .req_1(req_1), .data_1(data_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .valid_in(valid_in), .Data_in(Data_in),
    .link_ready(link_ready), .owner(owner)
  );

  phy_tx_arbiter #(.WORD_PERIOD(2), .SYNC_WORDS(SW), .SYNC_PATTERN(PAT)) dut_b (
    .clk_32f(clk), .reset(rst_b), .req_0(req_0b), .data_0(data_0b), .req_1(req_1b), .data_1(data_1b),
    .gnt_0(gnt_0b), .gnt_1(gnt_1b), .valid_in(valid_b), .Data_in(Data_b),
    .link_ready(link_b), .owner(owner_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected slot position, tracked independently of the DUT
  int bcnt;
  int nticks;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt   <= 0;
      nticks <= 0;
    end else if (bcnt == WP - 1) begin
      bcnt   <= 0;
      nticks <= nticks + 1;
    end else begin
      bcnt <= bcnt + 1;
    end
  end

  exp_t sbq[$];
  exp_t last_exp;
  exp_t mon_e;
  bit   mon_en = 1'b0;
  bit   m_rr, m_owner;

  // Slot-boundary compare against the queue; in between, everything must hold with no grant
  always @(negedge clk) begin
    if (reset && mon_en) begin
      if (bcnt == 0 && nticks > 0) begin
        if (sbq.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          mon_e = sbq.pop_front();
          chk("valid", valid_in, mon_e.v);
          chk("data", Data_in, mon_e.d);
          chk("owner", owner, mon_e.o);
          chk("gnt0", gnt_0, mon_e.g0);
          chk("gnt1", gnt_1, mon_e.g1);
          chk("link", link_ready, mon_e.lr);
          last_exp = mon_e;
        end
      end else begin
        chk("hold_valid", valid_in, last_exp.v);
        chk("hold_data", Data_in, last_exp.d);
        chk("hold_owner", owner, last_exp.o);
        chk("hold_link", link_ready, last_exp.lr);
        chk("no_gnt", {gnt_1, gnt_0}, 2'b00);
      end
    end
  end

  task automatic wait_bcnt(input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bcnt != v && n < 200);
    if (bcnt != v) chk("timeout_bcnt", bcnt, v);
  endtask

  task automatic wait_ticks(input int k);
    int n = 0;
    while (nticks < k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (nticks < k) chk("timeout_ticks", nticks, k);
  endtask

  task automatic push_sync();
    exp_t e;
    m_rr    = 1'b0;
    m_owner = 1'b0;
    for (int k = 0; k < SW; k++) begin
      e    = '0;
      e.v  = 1'b1;
      e.d  = PAT;
      e.o  = m_owner;
      e.lr = (k == SW - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic drive_slot(input bit r0, input logic [31:0] d0, input bit r1, input logic [31:0] d1);
    exp_t e;
    bit   w;
    wait_bcnt(WP - 1);
    req_0  = r0;
    data_0 = d0;
    req_1  = r1;
    data_1 = d1;
    e      = '0;
    e.lr   = 1'b1;
    if (r0 || r1) begin
      w       = (r0 && r1) ? m_rr : r1;
      e.v     = 1'b1;
      e.d     = w ? d1 : d0;
      e.g0    = !w;
      e.g1    = w;
      m_owner = w;
      m_rr    = !w;
    end
    e.o = m_owner;
    sbq.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, valid_in, 1'b0);
    chk({tag, "_data"}, Data_in, 32'h0);
    chk({tag, "_gnt"}, {gnt_1, gnt_0}, 2'b00);
    chk({tag, "_link"}, link_ready, 1'b0);
    chk({tag, "_owner"}, owner, 1'b0);
  endtask

  bit qb[$];

  task automatic run_fast();
    bit w;
    int n;
    data_0b = 32'hA5A5_0000;
    data_1b = 32'h5A5A_1111;
    req_0b  = 1'b1;
    req_1b  = 1'b1;
    for (int i = 0; i < 6; i++) qb.push_back(i[0]);
    @(negedge clk);
    #2 rst_b = 1'b1;
    n = 0;
    while (!(gnt_0b || gnt_1b) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_first_link", link_b, 1'b1);
    for (int i = 0; i < 6; i++) begin
      w = qb.pop_front();
      chk("b_gnt", {gnt_1b, gnt_0b}, w ? 2'b10 : 2'b01);
      chk("b_data", Data_b, w ? data_1b : data_0b);
      chk("b_owner", owner_b, w);
      @(negedge clk);
      chk("b_gap", {gnt_1b, gnt_0b}, 2'b00);
      chk("b_gap_data", Data_b, w ? data_1b : data_0b);
      @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b0;
    rst_b  = 1'b0;
    req_0  = 1'b0;
    req_1  = 1'b0;
    data_0 = 32'h0;
    data_1 = 32'h0;
    req_0b = 1'b0;
    req_1b = 1'b0;
    data_0b = 32'h0;
    data_1b = 32'h0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");

    run_fast();

    check_all_zero("rst_hold");
    req_0  = 1'b1;
    data_0 = 32'hDEAD_BEEF;
    push_sync();
    @(negedge clk);
    #2 reset = 1'b1;
    mon_en = 1'b1;
    wait_ticks(SW);

    drive_slot(1'b0, 32'h0, 1'b0, 32'h0);
    drive_slot(1'b1, 32'h1234_5678, 1'b0, 32'h0);
    drive_slot(1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive_slot(1'b1, 32'hA000_0000 + 32'(i), 1'b1, 32'hB000_0000 + 32'(i));
    end
    drive_slot(1'b0, 32'h0, 1'b0, 32'h0);
    wait_bcnt(3);
    req_1  = 1'b1;
    data_1 = 32'h7777_0001;
    wait_bcnt(10);
    req_1  = 1'b0;
    drive_slot(1'b0, 32'h0, 1'b0, 32'h0);

    drive_slot(1'b0, 32'h0, 1'b1, 32'hC0DE_0001);
    drive_slot(1'b0, 32'h0, 1'b1, 32'hC0DE_0002);
    wait_bcnt(7);
    chk("pre_rst_owner", owner, 1'b1);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    sbq.delete();
    last_exp = '0;
    repeat (3) @(negedge clk);
    push_sync();
    #2 reset = 1'b1;
    wait_ticks(SW);
    drive_slot(1'b0, 32'h0, 1'b1, 32'hC0DE_0003);
    drive_slot(1'b0, 32'h0, 1'b0, 32'h0);
    wait_bcnt(1);
    chk("sb_drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/phy_tx_arbiter.md
PHY_TX_ARBITER -- requirements
Module: phy_tx_arbiter

Interface
REQ-001 Parameter: WORD_PERIOD, default 16, clk_32f cycles per 32-bit word slot presented to the phy (legal range 2..255).
REQ-002 Parameter: SYNC_WORDS, default 4, number of sync words sent after reset before traffic (legal range 1..15).
REQ-003 Parameter: SYNC_PATTERN, default 32'hBCBC_BCBC, word value sent during sync.
REQ-004 Port: clk_32f  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 Port: req_0  input  1  requester 0 has a word pending.
REQ-007 Port: data_0  input  32  requester 0 word; held stable while req_0 is high.
REQ-008 Port: req_1  input  1  requester 1 has a word pending.
REQ-009 Port: data_1  input  32  requester 1 word; held stable while req_1 is high.
REQ-010 Port: gnt_0  output  1  one-cycle pulse: data_0 accepted.
REQ-011 Port: gnt_1  output  1  one-cycle pulse: data_1 accepted.
REQ-012 Port: valid_in  output  1  valid strobe to the phy transmit side.
REQ-013 Port: Data_in  output  32  word to the phy transmit side.
REQ-014 Port: link_ready  output  1  high once sync is complete.
REQ-015 Port: owner  output  1  requester that owns the current slot (0/1); meaningful only when valid_in=1 and link_ready=1.

Function
REQ-016 Slot counter SHALL count 0..WORD_PERIOD-1 and wrap to 0; slot_tick is asserted when the counter equals WORD_PERIOD-1.
REQ-017 FSM states SHALL be SYNC and ARB; reset release enters SYNC.
REQ-018 SYNC: on each slot_tick, valid_in<=1 and Data_in<=SYNC_PATTERN; the sync counter increments per slot_tick.
REQ-019 SYNC->ARB on the edge that loads the SYNC_WORDS-th sync word; link_ready<=1 on that same edge and stays 1 until reset.
REQ-020 SYNC: req_x SHALL be ignored; gnt_0 and gnt_1 stay 0.
REQ-021 ARB: arbitration occurs only on slot_tick; outside slot_tick, valid_in, Data_in and owner hold their values.
REQ-022 ARB on slot_tick, exactly one request: that requester wins.
REQ-023 ARB on slot_tick, both requests: the winner is the requester indicated by round-robin pointer rr (reset value 0).
REQ-024 On a win by requester x: gnt_x=1 for exactly the following cycle, Data_in<=data_x, valid_in<=1, owner<=x, and rr<=~x.
REQ-025 ARB on slot_tick, no request: valid_in<=0, Data_in<=32'h0, owner held, rr held.
REQ-026 Latency: request sampled at the slot_tick edge; the grant and phy word appear 1 cycle later; worst-case wait is 2*WORD_PERIOD cycles.
REQ-027 gnt_0 and gnt_1 SHALL never be high together, and at most one grant SHALL occur per slot.
REQ-028 The requester SHALL drop req_x, or present its next word, in the cycle after gnt_x; a held req_x is treated as a new word at the next slot_tick.
REQ-029 A request asserted mid-slot waits for the next slot_tick; a request withdrawn before slot_tick is not granted.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While reset=0: slot counter=0, sync counter=0, state=SYNC, rr=0, valid_in=0, Data_in=32'h0, gnt_0=0, gnt_1=0, link_ready=0, owner=0.
REQ-032 Reset asserted mid-operation clears all state immediately (asynchronously); the in-flight word is abandoned and the full sync sequence reruns after release.
REQ-033 The first slot_tick after release occurs WORD_PERIOD cycles after the first rising edge with reset=1.

Verification
REQ-034 Release reset with no requests -> 4 slots of valid_in=1, Data_in=BCBCBCBC; link_ready rises with the 4th sync word; then valid_in=0, Data_in=0.
REQ-035 After link_ready, req_0=1, data_0=32'h1234_5678 -> one gnt_0 pulse 1 cycle after slot_tick; Data_in=12345678, valid_in=1, owner=0 for 16 cycles.
REQ-036 req_0 and req_1 both held continuously with distinct data -> grants alternate 0,1,0,1 (rr starts at 0), one grant per 16 cycles; no grant ever overlaps.
REQ-037 req_1 asserted at slot counter 3 and dropped at 10 -> no gnt_1; valid_in=0 at the next slot.
REQ-038 reset pulsed low at slot counter 7 while owner=1 streams traffic -> all outputs 0 at once; after release, 4 sync words, and no grant before link_ready.
REQ-039 WORD_PERIOD=2, both requesters continuous -> a grant every 2 cycles, strictly alternating, with data matching the granted requester.
